// File: rtl/syst_ws_array.sv
// -----------------------------------------------------------------------------
// syst_ws_array
//
// Weight-stationary systolic array computing y = W * x.  W is a ROWS x COLS
// matrix of unsigned weights held inside the array; x is a COLS-element
// unsigned vector that enters as one whole (unskewed) vector per cycle.  The
// block skews the input internally, streams it through the node grid, and
// de-skews the row results so all rows of one output beat belong to the same
// input vector.
//
// Weights are loaded at runtime, one row per beat, while the block is in LOAD.
// A weight request seen in RUN first drains every in-flight vector with the old
// weights, so no result ever mixes old and new weights.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset (release synchronous to clk_i)
//   w_valid_i  : weight row beat valid
//   w_ready_o  : weight row accepted when w_valid_i & w_ready_o (LOAD only)
//   w_i        : one weight row, element c at [c*W_WIDTH +: W_WIDTH]
//   x_valid_i  : input vector valid
//   x_ready_o  : input vector accepted when x_valid_i & x_ready_o (RUN only)
//   x_i        : input vector, element c at [c*X_WIDTH +: X_WIDTH]
//   y_valid_o  : result vector valid (registered)
//   y_ready_i  : consumer ready; y_valid_o & !y_ready_i stalls the pipeline
//   y_o        : result vector, row r at [r*Y_WIDTH +: Y_WIDTH] (registered)
// -----------------------------------------------------------------------------
module syst_ws_array #(
    parameter int  ROWS    = 2,
    parameter int  COLS    = 3,
    parameter int  X_WIDTH = 8,
    parameter int  W_WIDTH = 8,
    localparam int Y_WIDTH = X_WIDTH + W_WIDTH + $clog2(COLS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    input  logic [COLS*W_WIDTH-1:0] w_i,
    input  logic                    x_valid_i,
    output logic                    x_ready_o,
    input  logic [COLS*X_WIDTH-1:0] x_i,
    output logic                    y_valid_o,
    input  logic                    y_ready_i,
    output logic [ROWS*Y_WIDTH-1:0] y_o
);

    // Number of pipeline slots between accepting a vector and the final
    // output register: skew + row walk + de-skew.
    localparam int L   = ROWS + COLS - 1;
    localparam int K_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [K_W-1:0]     k;
    logic [W_WIDTH-1:0] w_q [ROWS][COLS];

    logic [L-1:0]       vp;
    logic               stall;
    logic               advance;
    logic               w_fire;
    logic               x_fire;
    logic               pipe_empty;

    // x value entering node (r,c) and partial sum leaving node (r,c).
    logic [X_WIDTH-1:0] x_node  [ROWS][COLS];
    logic [Y_WIDTH-1:0] psum    [ROWS][COLS];
    // Row results after de-skew, all aligned to the same input vector.
    logic [Y_WIDTH-1:0] row_res [ROWS];

    // -------------------------------------------------------------------------
    // Handshake control.  A result sitting in the output register that the
    // consumer refuses freezes the entire datapath, so every in-flight vector
    // slips by exactly one cycle and nothing is lost or duplicated.  New
    // vectors are refused while frozen since there is no slot to put them in.
    // -------------------------------------------------------------------------
    assign stall      = y_valid_o & ~y_ready_i;
    assign advance    = ~stall;
    assign w_ready_o  = (state == LOAD);
    assign x_ready_o  = (state == RUN) & ~stall;
    assign w_fire     = w_valid_i & w_ready_o;
    assign x_fire     = x_valid_i & x_ready_o;
    assign pipe_empty = (vp == '0) & ~y_valid_o;

    // -------------------------------------------------------------------------
    // Control FSM and weight storage.  LOAD fills weight rows in order using
    // the row counter k; the last row hands over to RUN.  A weight request in
    // RUN moves to DRAIN, which waits until the valid pipe and output register
    // are empty before allowing new weights, so results computed with the old
    // weights are all delivered first.  Weights are never touched by stalls.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= LOAD;
            k     <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    w_q[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                LOAD: begin
                    if (w_fire) begin
                        for (int c = 0; c < COLS; c++) begin
                            w_q[k][c] <= w_i[c*W_WIDTH +: W_WIDTH];
                        end
                        if (k == K_W'(ROWS - 1)) begin
                            state <= RUN;
                            k     <= '0;
                        end else begin
                            k <= k + K_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (w_valid_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Valid tracking and output register.  One valid bit per pipeline slot
    // travels alongside the data; the data registers under an invalid slot
    // hold don't-care values.  The output register takes the de-skewed rows
    // and the last valid bit together, so y_o and y_valid_o stay aligned and
    // hold still during a stall.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vp        <= '0;
            y_valid_o <= 1'b0;
            y_o       <= '0;
        end else if (advance) begin
            vp[0] <= x_fire;
            for (int i = 1; i < L; i++) begin
                vp[i] <= vp[i-1];
            end
            y_valid_o <= vp[L-1];
            for (int r = 0; r < ROWS; r++) begin
                y_o[r*Y_WIDTH +: Y_WIDTH] <= row_res[r];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Input skew.  Element c is delayed by c registers before it reaches row
    // 0, so element c meets the partial sum that has already collected the
    // contributions of columns 0..c-1.  Column 0 feeds row 0 directly; the
    // node register itself is the first pipeline stage for that column.
    // -------------------------------------------------------------------------
    for (genvar c = 0; c < COLS; c++) begin : g_skew
        if (c == 0) begin : g_direct
            assign x_node[0][0] = x_i[0 +: X_WIDTH];
        end else begin : g_delay
            logic [X_WIDTH-1:0] sk [c];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < c; i++) begin
                        sk[i] <= '0;
                    end
                end else if (advance) begin
                    sk[0] <= x_i[c*X_WIDTH +: X_WIDTH];
                    for (int i = 1; i < c; i++) begin
                        sk[i] <= sk[i-1];
                    end
                end
            end

            assign x_node[0][c] = sk[c-1];
        end
    end

    // -------------------------------------------------------------------------
    // Node grid.  Each node adds its weight times the incoming x element to
    // the partial sum arriving from the left and registers the result.  The
    // x element is also registered and handed to the node below, which makes
    // row r see a given vector one cycle after row r-1.  Widening both
    // operands to the result width keeps the arithmetic full precision.
    // -------------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [Y_WIDTH-1:0] psum_in;
            logic [Y_WIDTH-1:0] psum_q;

            if (c == 0) begin : g_first
                assign psum_in = '0;
            end else begin : g_chain
                assign psum_in = psum[r][c-1];
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    psum_q <= '0;
                end else if (advance) begin
                    psum_q <= psum_in + Y_WIDTH'(w_q[r][c]) * Y_WIDTH'(x_node[r][c]);
                end
            end

            assign psum[r][c] = psum_q;

            // The bottom row has nobody below it, so its x is not forwarded.
            if (r < ROWS - 1) begin : g_fwd
                logic [X_WIDTH-1:0] x_q;

                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        x_q <= '0;
                    end else if (advance) begin
                        x_q <= x_node[r][c];
                    end
                end

                assign x_node[r+1][c] = x_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output de-skew.  Row r finishes r cycles after row 0, so it is delayed
    // by ROWS-1-r registers to line every row up with the bottom row.  The
    // bottom row needs no extra delay.
    // -------------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_deskew
        localparam int D = ROWS - 1 - r;

        if (D == 0) begin : g_pass
            assign row_res[r] = psum[r][COLS-1];
        end else begin : g_delay
            logic [Y_WIDTH-1:0] ds [D];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < D; i++) begin
                        ds[i] <= '0;
                    end
                end else if (advance) begin
                    ds[0] <= psum[r][COLS-1];
                    for (int i = 1; i < D; i++) begin
                        ds[i] <= ds[i-1];
                    end
                end
            end

            assign row_res[r] = ds[D-1];
        end
    end

endmodule

// File: tb/tb_syst_ws_array.sv
// -----------------------------------------------------------------------------
// tb_syst_ws_array
//
// Self-checking bench for syst_ws_array at its default size (2 x 3, 8-bit
// operands).  A reference model keeps the weight matrix as plain integers,
// computes each accepted vector's result as a dot product, and holds pending
// results in a queue tagged with the cycle they are due on the output.  Each
// stall cycle pushes every pending due cycle back by one.  Every cycle the
// output is compared against the head of that queue; directed steps add
// checks on ready signals, latency and the headline numeric results.
// -----------------------------------------------------------------------------
module tb_syst_ws_array;

    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int XW   = 8;
    localparam int WW   = 8;
    localparam int YW   = XW + WW + $clog2(COLS);
    localparam int L    = ROWS + COLS - 1;

    logic                 clk_i     = 1'b0;
    logic                 rst_ni    = 1'b0;
    logic                 w_valid_i = 1'b0;
    logic                 w_ready_o;
    logic [COLS*WW-1:0]   w_i       = '0;
    logic                 x_valid_i = 1'b0;
    logic                 x_ready_o;
    logic [COLS*XW-1:0]   x_i       = '0;
    logic                 y_valid_o;
    logic                 y_ready_i = 1'b1;
    logic [ROWS*YW-1:0]   y_o;

    typedef struct {
        longint             due;
        logic [ROWS*YW-1:0] y;
    } exp_t;

    exp_t        exp_q [$];
    int unsigned mw [ROWS][COLS];
    int          beats;
    longint      cyc;
    int          errors;
    int          checks;
    int          lat;

    syst_ws_array #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .X_WIDTH (XW),
        .W_WIDTH (WW)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .w_valid_i (w_valid_i),
        .w_ready_o (w_ready_o),
        .w_i       (w_i),
        .x_valid_i (x_valid_i),
        .x_ready_o (x_ready_o),
        .x_i       (x_i),
        .y_valid_o (y_valid_o),
        .y_ready_i (y_ready_i),
        .y_o       (y_o)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk_i = ~clk_i;

    // Hard stop in case a directed step gets stuck despite its own bounds.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [COLS*XW-1:0] pack_row(input int e0, input int e1, input int e2);
        pack_row = {XW'(e2), XW'(e1), XW'(e0)};
    endfunction

    function automatic logic [ROWS*YW-1:0] pack_y(input int y0, input int y1);
        pack_y = {YW'(y1), YW'(y0)};
    endfunction

    function automatic logic [COLS*XW-1:0] rand_vec();
        rand_vec = (COLS*XW)'($urandom);
    endfunction

    // Dot product of the model's weight matrix with one input vector.
    function automatic logic [ROWS*YW-1:0] ref_dot(input logic [COLS*XW-1:0] xv);
        logic [ROWS*YW-1:0] res;
        longint             acc;
        res = '0;
        for (int r = 0; r < ROWS; r++) begin
            acc = 0;
            for (int c = 0; c < COLS; c++) begin
                acc += longint'(mw[r][c]) * longint'(xv[c*XW +: XW]);
            end
            res[r*YW +: YW] = acc[YW-1:0];
        end
        ref_dot = res;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        beats = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                mw[r][c] = 0;
            end
        end
    endtask

    // One comparison: counts it, and on mismatch reports tag and both values.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare the registered output against the head of the expected queue.
    task automatic check_model();
        logic exp_valid;
        exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        checkOutput("y_valid", 64'(y_valid_o), 64'(exp_valid));
        if (exp_valid) begin
            checkOutput("y_data", 64'(y_o), 64'(exp_q[0].y));
        end
    endtask

    // Advance one clock with the inputs already driven, updating the model
    // from the handshakes that complete on this edge, then check at negedge.
    task automatic tick();
        logic               stall_pre;
        logic               xf;
        logic               wf;
        logic               hs;
        logic [COLS*XW-1:0] xs;
        logic [COLS*WW-1:0] ws;
        exp_t               e;
        #1;
        stall_pre = y_valid_o && !y_ready_i;
        xf        = x_valid_i && x_ready_o;
        wf        = w_valid_i && w_ready_o;
        hs        = y_valid_o && y_ready_i;
        xs        = x_i;
        ws        = w_i;
        @(posedge clk_i);
        cyc++;
        if (!rst_ni) begin
            clear_model();
        end else begin
            if (hs) begin
                void'(exp_q.pop_front());
            end
            if (stall_pre) begin
                foreach (exp_q[i]) begin
                    exp_q[i].due = exp_q[i].due + 1;
                end
            end
            if (wf) begin
                for (int c = 0; c < COLS; c++) begin
                    mw[beats % ROWS][c] = 32'(ws[c*WW +: WW]);
                end
                beats++;
            end
            if (xf) begin
                e.due = cyc + L;
                e.y   = ref_dot(xs);
                exp_q.push_back(e);
            end
        end
        @(negedge clk_i);
        check_model();
    endtask

    task automatic applyStimulus(input logic [COLS*XW-1:0] xv, input logic xval,
                                 input logic yr, input logic [COLS*WW-1:0] wv,
                                 input logic wval);
        x_i       = xv;
        x_valid_i = xval;
        y_ready_i = yr;
        w_i       = wv;
        w_valid_i = wval;
        tick();
    endtask

    // Present weight rows until all ROWS beats are taken; from RUN this first
    // waits out the drain.
    task automatic load_weights(input logic [COLS*WW-1:0] r0, input logic [COLS*WW-1:0] r1);
        int start;
        int guard;
        start = beats;
        guard = 0;
        while ((beats - start) < ROWS && guard < 100) begin
            applyStimulus(rand_vec(), 1'b0, 1'b1, ((beats - start) == 0) ? r0 : r1, 1'b1);
            guard++;
        end
        w_valid_i = 1'b0;
        if ((beats - start) < ROWS) begin
            checkOutput("load_timeout", 64'(beats - start), 64'(ROWS));
        end
    endtask

    // Idle with junk on x until a result shows up; lat counts the cycles.
    task automatic wait_valid();
        lat = 0;
        while (!y_valid_o && lat < 20) begin
            applyStimulus(rand_vec(), 1'b0, 1'b1, '0, 1'b0);
            lat++;
        end
        if (!y_valid_o) begin
            checkOutput("wait_valid_timeout", 64'(y_valid_o), 64'(1));
        end
    endtask

    task automatic drain_all();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 60) begin
            applyStimulus(rand_vec(), 1'b0, 1'b1, '0, 1'b0);
            guard++;
        end
        applyStimulus(rand_vec(), 1'b0, 1'b1, '0, 1'b0);
        if (exp_q.size() > 0) begin
            checkOutput("drain_timeout", 64'(exp_q.size()), 64'(0));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        clear_model();

        // Reset state
        rst_ni = 1'b0;
        repeat (3) tick();
        checkOutput("rst_y_valid", 64'(y_valid_o), 64'(0));
        checkOutput("rst_y_data", 64'(y_o), 64'(0));
        checkOutput("rst_x_ready", 64'(x_ready_o), 64'(0));
        checkOutput("rst_w_ready", 64'(w_ready_o), 64'(1));
        rst_ni = 1'b1;
        applyStimulus(rand_vec(), 1'b1, 1'b1, '0, 1'b0);
        checkOutput("idle_load_x_ready", 64'(x_ready_o), 64'(0));

        // Basic load and single vector with exact latency
        $display("[TB] load [2,3,4],[5,6,7] and single vector");
        load_weights(pack_row(2, 3, 4), pack_row(5, 6, 7));
        checkOutput("load_x_ready", 64'(x_ready_o), 64'(1));
        checkOutput("load_w_ready", 64'(w_ready_o), 64'(0));
        applyStimulus(pack_row(1, 2, 3), 1'b1, 1'b1, '0, 1'b0);
        wait_valid();
        checkOutput("single_latency", 64'(lat), 64'(4));
        checkOutput("single_y", 64'(y_o), 64'(pack_y(20, 38)));
        applyStimulus(rand_vec(), 1'b0, 1'b1, '0, 1'b0);
        checkOutput("single_one_cycle", 64'(y_valid_o), 64'(0));

        // Back-to-back vectors
        $display("[TB] back-to-back vectors");
        applyStimulus(pack_row(1, 2, 3), 1'b1, 1'b1, '0, 1'b0);
        applyStimulus(pack_row(0, 0, 1), 1'b1, 1'b1, '0, 1'b0);
        applyStimulus(pack_row(1, 1, 1), 1'b1, 1'b1, '0, 1'b0);
        wait_valid();
        checkOutput("b2b_first", 64'(y_o), 64'(pack_y(20, 38)));
        applyStimulus(rand_vec(), 1'b0, 1'b1, '0, 1'b0);
        checkOutput("b2b_second", 64'(y_o), 64'(pack_y(4, 7)));
        applyStimulus(rand_vec(), 1'b0, 1'b1, '0, 1'b0);
        checkOutput("b2b_third", 64'(y_o), 64'(pack_y(9, 18)));
        drain_all();

        // Full-scale operands
        $display("[TB] full-scale weights and inputs");
        load_weights(pack_row(255, 255, 255), pack_row(255, 255, 255));
        applyStimulus(pack_row(255, 255, 255), 1'b1, 1'b1, '0, 1'b0);
        wait_valid();
        checkOutput("max_y", 64'(y_o), 64'(pack_y(195075, 195075)));
        drain_all();

        // Backpressure
        $display("[TB] five-cycle stall with three vectors in flight");
        load_weights(pack_row(2, 3, 4), pack_row(5, 6, 7));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(rand_vec(), 1'b1, 1'b1, '0, 1'b0);
        end
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            x_i       = rand_vec();
            x_valid_i = 1'b1;
            y_ready_i = 1'b0;
            #1;
            checkOutput("stall_x_ready", 64'(x_ready_o), 64'(0));
            tick();
        end
        x_valid_i = 1'b0;
        drain_all();

        // Reload while vectors are in flight
        $display("[TB] weight reload mid-stream");
        applyStimulus(rand_vec(), 1'b1, 1'b1, '0, 1'b0);
        applyStimulus(rand_vec(), 1'b1, 1'b1, pack_row(1, 0, 0), 1'b1);
        checkOutput("drain_w_ready", 64'(w_ready_o), 64'(0));
        checkOutput("drain_x_ready", 64'(x_ready_o), 64'(0));
        load_weights(pack_row(1, 0, 0), pack_row(0, 1, 0));
        checkOutput("reload_x_ready", 64'(x_ready_o), 64'(1));
        applyStimulus(pack_row(9, 8, 7), 1'b1, 1'b1, '0, 1'b0);
        wait_valid();
        checkOutput("reload_y", 64'(y_o), 64'(pack_y(9, 8)));
        drain_all();

        // Random traffic with random backpressure
        $display("[TB] random traffic");
        load_weights(rand_vec(), rand_vec());
        for (int i = 0; i < 200; i++) begin
            applyStimulus(rand_vec(), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 3) != 0), '0, 1'b0);
        end
        drain_all();

        // Reset in the middle of a stream
        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(rand_vec(), 1'b1, 1'b1, '0, 1'b0);
        end
        rst_ni = 1'b0;
        #1;
        clear_model();
        checkOutput("midrst_y_valid", 64'(y_valid_o), 64'(0));
        checkOutput("midrst_x_ready", 64'(x_ready_o), 64'(0));
        checkOutput("midrst_w_ready", 64'(w_ready_o), 64'(1));
        repeat (2) tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x_i       = rand_vec();
            x_valid_i = 1'b1;
            #1;
            checkOutput("postrst_x_ready", 64'(x_ready_o), 64'(0));
            tick();
        end
        applyStimulus(pack_row(1, 2, 3), 1'b1, 1'b1, pack_row(1, 2, 3), 1'b1);
        checkOutput("one_beat_x_ready", 64'(x_ready_o), 64'(0));
        applyStimulus(pack_row(1, 2, 3), 1'b1, 1'b1, pack_row(4, 5, 6), 1'b1);
        checkOutput("two_beat_x_ready", 64'(x_ready_o), 64'(1));
        applyStimulus(pack_row(1, 2, 3), 1'b1, 1'b1, '0, 1'b0);
        wait_valid();
        checkOutput("postrst_y", 64'(y_o), 64'(pack_y(14, 32)));
        drain_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/syst_ws_array.md
# syst_ws_array

Parametrised weight-stationary systolic array computing y = W·x, with W a ROWS×COLS matrix held in the array and x a COLS-element vector streamed one per cycle. It generalises the fixed 2×3 array with constant weights: array size and widths are parameters, and it adds runtime weight loading, internal input skew/output de-skew, and valid/ready handshakes with backpressure. It sits between an input vector source and a result consumer in the DSP datapath.

## Interface
- ROWS, 2: output count (array rows)
- COLS, 3: input count (array columns)
- X_WIDTH, 8: unsigned input element width
- W_WIDTH, 8: unsigned weight width
- Y_WIDTH (localparam), X_WIDTH+W_WIDTH+$clog2(COLS): result width
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- w_valid_i  in  1  weight row beat valid
- w_ready_o  out  1  weight row accepted when w_valid_i & w_ready_o
- w_i  in  COLS*W_WIDTH  one weight row; element c at bits [c*W_WIDTH +: W_WIDTH]
- x_valid_i  in  1  input vector valid
- x_ready_o  out  1  input vector accepted when x_valid_i & x_ready_o
- x_i  in  COLS*X_WIDTH  input vector, element c at [c*X_WIDTH +: X_WIDTH], unskewed
- y_valid_o  out  1  result vector valid
- y_ready_i  in  1  consumer ready
- y_o  out  ROWS*Y_WIDTH  result vector, row r at [r*Y_WIDTH +: Y_WIDTH], all rows aligned

## Operation
- Node (r,c): registers psum_out = psum_in + w[r][c]*x_in; forwards x_in to node (r+1,c) through one register. psum_in of column 0 is 0; row r result leaves column COLS-1.
- Input skew: element c delayed c registers before row 0. Output de-skew: row r delayed ROWS-1-r registers. All rows of y_o belong to the same x vector.
- Arithmetic unsigned, full precision, no truncation or saturation.
- Valid shift register of length L = ROWS+COLS-1 tracks accepted vectors; data registers under invalid slots are don't-care.
- FSM states: LOAD, RUN, DRAIN. Reset state LOAD.
  - LOAD: w_ready_o=1, x_ready_o=0. Row counter k (0..ROWS-1) starts at 0; each accepted beat writes w_i into weight row k, k++. Beat with k=ROWS-1 → RUN, k←0.
  - RUN: w_ready_o=0, x_ready_o = !stall. w_valid_i=1 → DRAIN next cycle. An x vector presented in the same cycle is still accepted.
  - DRAIN: x_ready_o=0, w_ready_o=0. When valid pipe and y_valid_o are all zero → LOAD next cycle.
- Stall = y_valid_o & !y_ready_i. Stall freezes every skew, node, de-skew, valid and output register; weights unaffected.

## Timing
- Reset (asynchronous, rst_ni=0): weights 0, all pipeline/valid registers 0, y_o=0, y_valid_o=0, x_ready_o=0, w_ready_o=1 (state LOAD), k=0. Release synchronous to clk_i.
- Latency: vector accepted at edge n appears on y_o with y_valid_o=1 after edge n+L (default L=4) absent stalls; throughput one vector/cycle.
- y_o/y_valid_o registered, held stable while stalled.
- Each stall cycle adds exactly one cycle to every in-flight vector; no vector dropped or duplicated.
- Weight load from RUN: min cycles RUN→first w beat = 1 + drain time; full reload ROWS beats; first x accept earliest the cycle after last beat.
- Weight reload mid-stream never mixes old and new weights within one vector.
- w_valid_i gaps in LOAD: counter holds. Reset mid-load or mid-stream: everything discarded, back to LOAD with zero weights.

## Test plan
- Reset then load rows [2,3,4],[5,6,7]; x=(1,2,3) → after 4 cycles y=(20,38), y_valid_o one cycle.
- Back-to-back x=(1,2,3),(0,0,1),(1,1,1) on consecutive cycles → y=(20,38),(4,7),(9,18) on consecutive cycles starting 4 cycles after first accept.
- Weights all 255, x all 255 → y=(195075,195075), no overflow in 18 bits.
- Stream 3 vectors, y_ready_i=0 for 5 cycles when first result valid → y_o held stable, x_ready_o=0 during stall, all 3 results later in order.
- In RUN with 2 vectors in flight assert w_valid_i with new rows [1,0,0],[0,1,0] → old results (old weights) delivered, w_ready_o rises after drain, next x=(9,8,7) → y=(9,8).
- Assert rst_ni=0 mid-stream → y_valid_o=0 immediately, x_ready_o=0, w_ready_o=1; after release x never accepted until ROWS weight beats.
